// File: rtl/reg_dump_reader_if.sv
// rtl/reg_dump_reader_if.sv - register-file read port and word output stream of the dump engine
//
// Purpose: bundles the two register-file read ports and the valid/ready word
// stream leaving the dump engine.
// Signals:
//   srcA, srcB     read addresses (engine -> register file)
//   ReadA, ReadB   combinational read data (register file -> engine)
//   OutValid       word stream valid (engine -> consumer)
//   OutReady       word stream ready (consumer -> engine)
//   OutData        register contents
//   OutAddr        register address of OutData
//   OutLast        final word of the dump
// Modports: master = dump engine side, slave = register file / consumer side.

interface reg_dump_reader_if #(
  parameter int W = 8,
  parameter int D = 4
);
  logic [D-1:0] srcA;
  logic [D-1:0] srcB;
  logic [W-1:0] ReadA;
  logic [W-1:0] ReadB;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] OutData;
  logic [D-1:0] OutAddr;
  logic         OutLast;

  modport master (
    output srcA, srcB, OutValid, OutData, OutAddr, OutLast,
    input  ReadA, ReadB, OutReady
  );

  modport slave (
    input  srcA, srcB, OutValid, OutData, OutAddr, OutLast,
    output ReadA, ReadB, OutReady
  );
endinterface

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks the register file in address pairs and streams every word out
//
// Purpose: on a Start pulse in IDLE, reads the register file two words at a
// time (even address on port A, odd on port B), captures the pair in one
// cycle and streams both words with their addresses over valid/ready.
// Optional feature macro: REG_DUMP_CHECKSUM_EN appends an XOR checksum word
// (OutAddr=0, OutLast=1) after the last register.
// Ports:
//   CLK     clock, rising edge
//   ResetN  asynchronous active-low reset
//   Start   begin a dump (only honoured in IDLE)
//   bus     reg_dump_reader_if.master: read ports + output word stream
//   Busy    high in every state except IDLE
//   Done    one-cycle pulse when the dump completes

module reg_dump_reader #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              Start,
  reg_dump_reader_if.master bus,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [2:0] {
    sIdle  = 3'd0,
    sFetch = 3'd1,
    sSendA = 3'd2,
    sSendB = 3'd3,
`ifdef REG_DUMP_CHECKSUM_EN
    sSum   = 3'd5,
`endif
    sDone  = 3'd4
  } stateT;

  // Base of the final pair; comparing against it stops the walk before
  // base+2 could wrap back to 0.
  localparam logic [D-1:0] LastBase = D'(2 ** D - 2);
  localparam logic [D-1:0] Step     = D'(2);
  localparam logic [D-1:0] One      = D'(1);

  stateT        state;
  stateT        nextState;
  logic [D-1:0] base;
  logic [W-1:0] bufA;
  logic [W-1:0] bufB;
  logic         lastPair;

  assign lastPair = (base == LastBase);

  // Read addresses come straight from the base register, so nothing on the
  // input side reaches an output combinationally.
  assign bus.srcA = base;
  assign bus.srcB = base | One;

  // State register
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) state <= sIdle;
    else         state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      sIdle:  if (Start) nextState = sFetch;
      sFetch: nextState = sSendA;
      sSendA: if (bus.OutReady) nextState = sSendB;
      sSendB: begin
        if (bus.OutReady) begin
          if (lastPair) begin
`ifdef REG_DUMP_CHECKSUM_EN
            nextState = sSum;
`else
            nextState = sDone;
`endif
          end else begin
            nextState = sFetch;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      sSum:   if (bus.OutReady) nextState = sDone;
`endif
      sDone:  nextState = sIdle;
      default: nextState = sIdle;
    endcase
  end

  // Pair address and capture buffers. Both read ports are captured on the
  // same edge so a pair is always self-consistent.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      base <= '0;
      bufA <= '0;
      bufB <= '0;
    end else begin
      if (state == sIdle && Start) begin
        base <= '0;
      end else if (state == sSendB && bus.OutReady && !lastPair) begin
        base <= base + Step;
      end
      if (state == sFetch) begin
        bufA <= bus.ReadA;
        bufB <= bus.ReadB;
      end
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [W-1:0] acc;

  // Folding in at capture time covers every register exactly once and
  // matches the values actually streamed.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      acc <= '0;
    end else if (state == sIdle && Start) begin
      acc <= '0;
    end else if (state == sFetch) begin
      acc <= acc ^ bus.ReadA ^ bus.ReadB;
    end
  end
`endif

  // Output logic: outputs depend on registered state only, so they hold
  // steady while a word waits for OutReady.
  always_comb begin
    bus.OutValid = 1'b0;
    bus.OutData  = '0;
    bus.OutAddr  = '0;
    bus.OutLast  = 1'b0;
    Done         = 1'b0;
    Busy         = (state != sIdle);
    case (state)
      sSendA: begin
        bus.OutValid = 1'b1;
        bus.OutData  = bufA;
        bus.OutAddr  = base;
      end
      sSendB: begin
        bus.OutValid = 1'b1;
        bus.OutData  = bufB;
        bus.OutAddr  = base | One;
`ifndef REG_DUMP_CHECKSUM_EN
        bus.OutLast  = lastPair;
`endif
      end
`ifdef REG_DUMP_CHECKSUM_EN
      sSum: begin
        bus.OutValid = 1'b1;
        bus.OutData  = acc;
        bus.OutAddr  = '0;
        bus.OutLast  = 1'b1;
      end
`endif
      sDone: Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - self-checking bench for reg_dump_reader
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int Extra = 1;
`else
  localparam int Extra = 0;
`endif
  localparam int NWords   = 16 + Extra;
  localparam int BaseDone = 25 + Extra;

  logic CLK = 1'b0;
  logic ResetN;
  logic Start;
  logic Busy;
  logic Done;

  always #5 CLK = ~CLK;

  reg_dump_reader_if #(.W(8), .D(4)) bus ();

  reg_dump_reader #(.W(8), .D(4)) dut (
    .CLK    (CLK),
    .ResetN (ResetN),
    .Start  (Start),
    .bus    (bus),
    .Busy   (Busy),
    .Done   (Done)
  );

  // Register file model: combinational read ports.
  logic [7:0] regs [16];
  assign bus.ReadA = regs[bus.srcA];
  assign bus.ReadB = regs[bus.srcB];

  int errors = 0;
  int checks = 0;

  int         gotAddr[$];
  logic [7:0] gotData[$];
  bit         gotLast[$];
  logic [7:0] stallData[$];
  int         stallAddrQ[$];
  int         cyc, doneCycle, doneCount, stalls;

  logic [7:0] preRegs [16];
  logic [7:0] postRegs [16];
  int         expAddr[$];
  logic [7:0] expData[$];
  bit         expLast[$];

  task automatic preload_basic();
    for (int n = 0; n < 16; n++) regs[n] = 8'(n * 8'h11);
    regs[1] = 8'h67;
    regs[2] = 8'hFE;
    preRegs  = regs;
    postRegs = regs;
  endtask

  task automatic preload_random();
    for (int n = 0; n < 16; n++) regs[n] = 8'($urandom_range(0, 255));
    preRegs  = regs;
    postRegs = regs;
  endtask

  // Reference: every register in address order; a pair shows the value the
  // file held when that pair was read. Writes issued while pair wrBase is on
  // the output are seen only by later pairs.
  task automatic build_exp(input int wrBase);
    logic [7:0] sum;
    logic [7:0] v;
    sum = 8'h00;
    expAddr.delete(); expData.delete(); expLast.delete();
    for (int a = 0; a < 16; a++) begin
      v = (wrBase >= 0 && (a / 2) * 2 > wrBase) ? postRegs[a] : preRegs[a];
      sum ^= v;
      expAddr.push_back(a);
      expData.push_back(v);
      expLast.push_back(Extra == 0 && a == 15);
    end
    if (Extra != 0) begin
      expAddr.push_back(0);
      expData.push_back(sum);
      expLast.push_back(1'b1);
    end
  endtask

  // Pulses Start in the current cycle (cycle 0) and runs until the cycle
  // after Done. Must be entered 1 time unit after a rising edge.
  task automatic run_dump(input int stallAddr, input int stallLen, input bit rndReady,
                          input int restartCyc, input int wrAddr);
    int  stallLeft;
    bit  wrDone;
    gotAddr.delete(); gotData.delete(); gotLast.delete();
    stallData.delete(); stallAddrQ.delete();
    cyc = 0; doneCycle = -1; doneCount = 0; stalls = 0;
    stallLeft = stallLen; wrDone = 0;
    Start = 1'b1;
    bus.OutReady = 1'b1;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      Start = (cyc == restartCyc);
      if (rndReady) bus.OutReady = ($urandom_range(0, 3) != 0);
      else if (bus.OutValid && int'(bus.OutAddr) == stallAddr && stallLeft > 0) begin
        bus.OutReady = 1'b0;
        stallLeft--;
      end else bus.OutReady = 1'b1;
      if (bus.OutValid && !bus.OutReady) begin
        stalls++;
        stallData.push_back(bus.OutData);
        stallAddrQ.push_back(int'(bus.OutAddr));
      end
      if (bus.OutValid && bus.OutReady) begin
        gotAddr.push_back(int'(bus.OutAddr));
        gotData.push_back(bus.OutData);
        gotLast.push_back(bus.OutLast);
      end
      if (wrAddr >= 0 && !wrDone && bus.OutValid && int'(bus.OutAddr) == wrAddr) begin
        regs = postRegs;
        wrDone = 1;
      end
      if (Done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = cyc;
      end
      if (doneCycle >= 0 && cyc == doneCycle + 1) break;
      if (cyc > 1000) begin
        errors++; checks++;
        $display("FAIL dump_timeout: no completion after %0d cycles, required Done", cyc);
        break;
      end
    end
    Start = 1'b0;
    bus.OutReady = 1'b1;
  endtask

  task automatic test_reset();
    ResetN = 1'b1; Start = 1'b0; bus.OutReady = 1'b1;
    for (int n = 0; n < 16; n++) regs[n] = 8'h00;
    #1 ResetN = 1'b0;
    #2;
    checks++;
    if ({bus.OutValid, bus.OutData, bus.OutAddr, bus.OutLast, Busy, Done} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h addr=%h last=%b busy=%b done=%b, required all 0",
               bus.OutValid, bus.OutData, bus.OutAddr, bus.OutLast, Busy, Done);
    end
    checks++;
    if (bus.srcA !== 4'd0 || bus.srcB !== 4'd1) begin
      errors++;
      $display("FAIL reset_src: srcA=%0d srcB=%0d, required 0/1", bus.srcA, bus.srcB);
    end
    @(posedge CLK); @(posedge CLK); #1 ResetN = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (Busy !== 1'b0 || bus.OutValid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b valid=%b, required 0/0", Busy, bus.OutValid);
    end
  endtask

  task automatic test_basic();
    preload_basic();
    build_exp(-1);
    run_dump(-1, 0, 0, -1, -1);
    checks++;
    if (gotAddr.size() != NWords) begin
      errors++;
      $display("FAIL basic_count: got %0d words, required %0d", gotAddr.size(), NWords);
    end
    for (int i = 0; i < gotAddr.size() && i < NWords; i++) begin
      checks++;
      if (gotAddr[i] != expAddr[i] || gotData[i] !== expData[i] || gotLast[i] != expLast[i]) begin
        errors++;
        $display("FAIL basic_word%0d: got addr=%0d data=%h last=%0d, required addr=%0d data=%h last=%0d",
                 i, gotAddr[i], gotData[i], gotLast[i], expAddr[i], expData[i], expLast[i]);
      end
    end
    checks++;
    if (gotData.size() >= 16 && (gotData[1] !== 8'h67 || gotData[2] !== 8'hFE || gotData[15] !== 8'hFF)) begin
      errors++;
      $display("FAIL basic_known: words1/2/15=%h/%h/%h, required 67/FE/FF", gotData[1], gotData[2], gotData[15]);
    end
    checks++;
    if (doneCycle != BaseDone || doneCount != 1) begin
      errors++;
      $display("FAIL basic_done: cycle=%0d count=%0d, required cycle=%0d count=1", doneCycle, doneCount, BaseDone);
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: busy=%b after Done, required 0", Busy);
    end
  endtask

  task automatic test_backpressure();
    preload_basic();
    build_exp(-1);
    run_dump(4, 5, 0, -1, -1);
    checks++;
    if (stalls != 5) begin
      errors++;
      $display("FAIL bp_stalls: got %0d stall cycles, required 5", stalls);
    end
    foreach (stallData[i]) begin
      checks++;
      if (stallData[i] !== 8'h44 || stallAddrQ[i] != 4) begin
        errors++;
        $display("FAIL bp_hold%0d: data=%h addr=%0d, required 44/4", i, stallData[i], stallAddrQ[i]);
      end
    end
    checks++;
    if (gotAddr.size() != NWords) begin
      errors++;
      $display("FAIL bp_count: got %0d words, required %0d", gotAddr.size(), NWords);
    end
    for (int i = 0; i < gotAddr.size() && i < NWords; i++) begin
      checks++;
      if (gotAddr[i] != expAddr[i] || gotData[i] !== expData[i] || gotLast[i] != expLast[i]) begin
        errors++;
        $display("FAIL bp_word%0d: got addr=%0d data=%h last=%0d, required addr=%0d data=%h last=%0d",
                 i, gotAddr[i], gotData[i], gotLast[i], expAddr[i], expData[i], expLast[i]);
      end
    end
    checks++;
    if (doneCycle != BaseDone + 5) begin
      errors++;
      $display("FAIL bp_done: cycle=%0d, required %0d", doneCycle, BaseDone + 5);
    end
  endtask

  task automatic test_start_while_busy();
    for (int pass = 0; pass < 2; pass++) begin
      preload_basic();
      build_exp(-1);
      run_dump(-1, 0, 0, (pass == 0) ? 10 : -1, -1);
      checks++;
      if (gotAddr.size() != NWords || doneCount != 1 || doneCycle != BaseDone) begin
        errors++;
        $display("FAIL busy_start_pass%0d: words=%0d dones=%0d doneCycle=%0d, required %0d/1/%0d",
                 pass, gotAddr.size(), doneCount, doneCycle, NWords, BaseDone);
      end
      for (int i = 0; i < gotAddr.size() && i < NWords; i++) begin
        checks++;
        if (gotAddr[i] != expAddr[i] || gotData[i] !== expData[i]) begin
          errors++;
          $display("FAIL busy_start_word%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                   i, gotAddr[i], gotData[i], expAddr[i], expData[i]);
        end
      end
    end
  endtask

  task automatic test_concurrent_write();
    preload_basic();
    postRegs[6]  = 8'hAB;
    postRegs[10] = 8'h3C;
    build_exp(6);
    run_dump(-1, 0, 0, -1, 6);
    checks++;
    if (gotData.size() >= 16 && (gotData[6] !== 8'h66 || gotData[10] !== 8'h3C)) begin
      errors++;
      $display("FAIL cw_first: r6=%h r10=%h, required 66/3C", gotData[6], gotData[10]);
    end
    for (int i = 0; i < gotAddr.size() && i < NWords; i++) begin
      checks++;
      if (gotData[i] !== expData[i]) begin
        errors++;
        $display("FAIL cw_word%0d: got %h, required %h", i, gotData[i], expData[i]);
      end
    end
    preRegs = regs;
    build_exp(-1);
    run_dump(-1, 0, 0, -1, -1);
    checks++;
    if (gotData.size() >= 16 && gotData[6] !== 8'hAB) begin
      errors++;
      $display("FAIL cw_second: r6=%h, required AB", gotData[6]);
    end
    checks++;
    if (gotData.size() != expData.size() || (gotData.size() == NWords && gotData[NWords-1] !== expData[NWords-1])) begin
      errors++;
      $display("FAIL cw_second_tail: words=%0d, required %0d with final word %h", gotData.size(), NWords, expData[NWords-1]);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit found;
    bit sawValid;
    preload_basic();
    found = 0;
    Start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge CLK); #1;
      Start = 1'b0;
      if (bus.OutValid && bus.OutAddr == 4'd9) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_reach: address 9 never offered, required it to be");
    end
    #2 ResetN = 1'b0;
    #1;
    checks++;
    if ({bus.OutValid, bus.OutData, bus.OutAddr, bus.OutLast, Busy, Done} !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: valid=%b data=%h addr=%h last=%b busy=%b done=%b, required all 0",
               bus.OutValid, bus.OutData, bus.OutAddr, bus.OutLast, Busy, Done);
    end
    checks++;
    if (bus.srcA !== 4'd0 || bus.srcB !== 4'd1) begin
      errors++;
      $display("FAIL mid_reset_src: srcA=%0d srcB=%0d, required 0/1", bus.srcA, bus.srcB);
    end
    @(posedge CLK); #2 ResetN = 1'b1;
    sawValid = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      if (bus.OutValid || Busy) sawValid = 1;
    end
    checks++;
    if (sawValid) begin
      errors++;
      $display("FAIL mid_reset_quiet: activity seen after reset, required none");
    end
    build_exp(-1);
    run_dump(-1, 0, 0, -1, -1);
    checks++;
    if (gotAddr.size() != NWords || (gotAddr.size() > 0 && gotAddr[0] != 0) || doneCycle != BaseDone) begin
      errors++;
      $display("FAIL mid_reset_restart: words=%0d first=%0d doneCycle=%0d, required %0d/0/%0d",
               gotAddr.size(), (gotAddr.size() > 0) ? gotAddr[0] : -1, doneCycle, NWords, BaseDone);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      preload_random();
      build_exp(-1);
      run_dump(-1, 0, 1, -1, -1);
      checks++;
      if (gotAddr.size() != NWords) begin
        errors++;
        $display("FAIL rnd%0d_count: got %0d words, required %0d", it, gotAddr.size(), NWords);
      end
      for (int i = 0; i < gotAddr.size() && i < NWords; i++) begin
        checks++;
        if (gotAddr[i] != expAddr[i] || gotData[i] !== expData[i] || gotLast[i] != expLast[i]) begin
          errors++;
          $display("FAIL rnd%0d_word%0d: got addr=%0d data=%h last=%0d, required addr=%0d data=%h last=%0d",
                   it, i, gotAddr[i], gotData[i], gotLast[i], expAddr[i], expData[i], expLast[i]);
        end
      end
      checks++;
      if (doneCycle != BaseDone + stalls || doneCount != 1) begin
        errors++;
        $display("FAIL rnd%0d_done: cycle=%0d count=%0d, required cycle=%0d count=1",
                 it, doneCycle, doneCount, BaseDone + stalls);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_while_busy();
    test_concurrent_write();
    test_reset_mid_dump();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
